// File: rtl/vxe_intr_pkg.sv
// Shared definitions for the VxE interrupt controller and its service agent.
// Holds the FSM state encoding, default sizes and the id-width helper.
package vxe_intr_pkg;

  localparam int NR_INT_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_ACK     = 3'd3,
    ST_SETTLE  = 3'd4
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vxe_rr_pick.sv
// Combinational round-robin find-first-set: returns the first set request bit
// strictly after ptr, wrapping around to index 0.
module vxe_rr_pick
  import vxe_intr_pkg::*;
#(
  parameter int NR_INT = NR_INT_DEF,
  localparam int IDW   = id_width(NR_INT)
) (
  input  logic [NR_INT-1:0] req,
  input  logic [IDW-1:0]    ptr,
  output logic              found,
  output logic [IDW-1:0]    idx
);

  logic              found_s;
  logic [IDW-1:0]    idx_s;

  // Scan from the farthest offset down so the nearest candidate after ptr wins.
  always_comb begin
    found_s = 1'b0;
    idx_s   = {IDW{1'b0}};
    for (int i = NR_INT; i >= 1; i--) begin
      int cand;
      cand    = (int'(ptr) + i) % NR_INT;
      found_s = req[cand] ? 1'b1 : found_s;
      idx_s   = req[cand] ? IDW'(cand) : idx_s;
    end
  end

  assign found = found_s;
  assign idx   = idx_s;

endmodule

// File: rtl/vxe_intr_svc.sv
// Service agent for vxe_intr_unit: picks pending sources round-robin, hands
// one event per source to a valid/ready consumer, then acks that source.
module vxe_intr_svc
  import vxe_intr_pkg::*;
#(
  parameter int NR_INT     = NR_INT_DEF,
  parameter int ACK_SETTLE = 2,
  parameter int CNT_W      = CNT_W_DEF,
  localparam int IDW       = id_width(NR_INT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_intr,
  input  logic [NR_INT-1:0] i_active,
  output logic              o_ack_en,
  output logic [NR_INT-1:0] o_ack,
  output logic              o_evt_valid,
  output logic [IDW-1:0]    o_evt_id,
  input  logic              i_evt_ready,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_evt_cnt
);

  localparam int SW = (ACK_SETTLE > 1) ? $clog2(ACK_SETTLE) : 1;

  state_e            state_r, state_s;
  logic              valid_r, valid_s;
  logic [IDW-1:0]    id_r, id_s;
  logic              ack_en_r, ack_en_s;
  logic [NR_INT-1:0] ack_r, ack_s;
  logic              busy_r;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [IDW-1:0]    ptr_r, ptr_s;
  logic [SW-1:0]     settle_r, settle_s;
  logic              found_s;
  logic [IDW-1:0]    pick_idx_s;

  vxe_rr_pick #(.NR_INT(NR_INT)) u_pick (
    .req   (i_active),
    .ptr   (ptr_r),
    .found (found_s),
    .idx   (pick_idx_s)
  );

  // Next-state and next-output logic; the ack strobe defaults low every cycle.
  always_comb begin
    state_s  = state_r;
    valid_s  = valid_r;
    id_s     = id_r;
    ack_en_s = 1'b0;
    ack_s    = {NR_INT{1'b0}};
    ptr_s    = ptr_r;
    cnt_s    = cnt_r;
    settle_s = settle_r;
    case (state_r)
      ST_IDLE: begin
        if (i_enable && i_intr) begin
          state_s = ST_CAPTURE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        // An all-zero vector means the line was masked away before we looked.
        if (found_s) begin
          valid_s = 1'b1;
          id_s    = pick_idx_s;
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (i_evt_ready) begin
          valid_s  = 1'b0;
          ack_en_s = 1'b1;
          ack_s    = NR_INT'(1'b1) << id_r;
          state_s  = ST_ACK;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_ACK: begin
        ptr_s    = id_r;
        cnt_s    = cnt_r + CNT_W'(1'b1);
        settle_s = SW'(ACK_SETTLE - 1);
        state_s  = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Give vxe_intr_unit time to clear the acked bit before resampling.
        if (settle_r == {SW{1'b0}}) begin
          state_s = ST_IDLE;
        end else begin
          settle_s = settle_r - SW'(1'b1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight event without ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      valid_r  <= 1'b0;
      id_r     <= {IDW{1'b0}};
      ack_en_r <= 1'b0;
      ack_r    <= {NR_INT{1'b0}};
      busy_r   <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      ptr_r    <= IDW'(NR_INT - 1);
      settle_r <= {SW{1'b0}};
    end else begin
      state_r  <= state_s;
      valid_r  <= valid_s;
      id_r     <= id_s;
      ack_en_r <= ack_en_s;
      ack_r    <= ack_s;
      busy_r   <= (state_s != ST_IDLE);
      cnt_r    <= cnt_s;
      ptr_r    <= ptr_s;
      settle_r <= settle_s;
    end
  end

  assign o_ack_en    = ack_en_r;
  assign o_ack       = ack_r;
  assign o_evt_valid = valid_r;
  assign o_evt_id    = id_r;
  assign o_busy      = busy_r;
  assign o_evt_cnt   = cnt_r;

endmodule
